// File: rtl/weight_read_sequencer_if.sv
// Handshake and memory bus of the weight read sequencer.
// The slave modport is the sequencer; the master modport is the sample source, memory and sink.
interface weight_read_sequencer_if #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16
);
  logic                  start;
  logic [dataWidth-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_ren;
  logic [addressWidth:0] mem_raddr;
  logic [dataWidth-1:0]  mem_wout;
  logic [dataWidth-1:0]  out_data;
  logic [dataWidth-1:0]  out_weight;
  logic                  out_valid;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, in_data, in_valid, mem_wout,
    output in_ready, mem_ren, mem_raddr, out_data, out_weight,
           out_valid, out_last, busy, done
  );

  modport master (
    output start, in_data, in_valid, mem_wout,
    input  in_ready, mem_ren, mem_raddr, out_data, out_weight,
           out_valid, out_last, busy, done
  );
endinterface

// File: rtl/weight_read_sequencer.sv
// Streams input samples against sequential weight-memory reads, pairing each
// sample with its weight one cycle later; one pass covers numWeight weights.
module weight_read_sequencer #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int numWeight    = 784
) (
  input logic                    clk,
  input logic                    rst,
  weight_read_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [addressWidth:0] LAST = (addressWidth+1)'(numWeight - 1);

  state_t                state;
  logic [addressWidth:0] cnt;
  logic [dataWidth-1:0]  sample_q;
  logic                  in_ready_q, out_valid_q, out_last_q, busy_q, done_q;
  logic                  accept, last_hit;

  assign accept   = bus.in_valid & in_ready_q;
  assign last_hit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sample_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // The pair for an accept appears next cycle; the weight arrives from memory then.
      out_valid_q <= accept;
      out_last_q  <= accept & last_hit;
      done_q      <= accept & last_hit;
      if (accept) sample_q <= bus.in_data;
      case (state)
        IDLE: if (bus.start) begin
          state      <= RUN;
          cnt        <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        RUN: if (accept) begin
          if (last_hit) begin
            // Counter parks at zero so it never passes numWeight-1.
            state      <= DRAIN;
            cnt        <= '0;
            in_ready_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_ren    = accept;
  assign bus.mem_raddr  = cnt;
  assign bus.out_data   = sample_q;
  assign bus.out_weight = bus.mem_wout;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: doc/weight_read_sequencer.md
WEIGHT_READ_SEQUENCER -- requirements
Module: weight_read_sequencer

Interface
REQ-001 Parameter addressWidth, default 10, SHALL set the weight-memory depth as 2**addressWidth words.
REQ-002 Parameter dataWidth, default 16, SHALL set the input-sample and weight word width.
REQ-003 Parameter numWeight, default 784, SHALL set the weights per neuron pass, legal range 1..2**addressWidth.
REQ-004 Clock and reset SHALL be exactly as follows: one clock; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a neuron pass.
- in_data  in  dataWidth  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts in_data this cycle.
- mem_ren  out  1  weight-memory read enable.
- mem_raddr  out  addressWidth+1  weight-memory read address.
- mem_wout  in  dataWidth  weight-memory read data, valid one cycle after mem_ren.
- out_data  out  dataWidth  sample aligned with its weight.
- out_weight  out  dataWidth  weight for out_data.
- out_valid  out  1  out_data/out_weight pair valid.
- out_last  out  1  marks the pair for weight index numWeight-1.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-007 IDLE: in_ready=0, busy=0; start=1 -> RUN, address counter cleared to 0.
REQ-008 RUN: in_ready=1, busy=1; any start pulse SHALL be ignored.
REQ-009 Accept SHALL be defined as in_valid AND in_ready; mem_ren SHALL equal accept combinationally and mem_raddr SHALL equal the counter value.
REQ-010 On accept, in_data SHALL be registered and the counter incremented by 1; no accept -> counter holds and no read occurs.
REQ-011 Exactly one cycle after an accept, out_valid=1 with out_weight=mem_wout and out_data equal to the sample registered at that accept; otherwise out_valid=0.
REQ-012 An accept at counter value numWeight-1 SHALL move RUN -> DRAIN; in_ready SHALL be 0 in DRAIN.
REQ-013 DRAIN: the trailing pair SHALL be emitted with out_valid=1 and out_last=1, done=1 in the same cycle, then the FSM SHALL return to IDLE.
REQ-014 out_last SHALL be 1 only on the pair for index numWeight-1.
REQ-015 Back-to-back accepts SHALL sustain one pair per cycle; gaps in in_valid SHALL produce matching gaps in out_valid with no reordering or drop.
REQ-016 The counter SHALL never exceed numWeight-1; numWeight=1 SHALL yield a single accept, then DRAIN.
REQ-017 A start arriving in the DRAIN cycle SHALL be ignored; a new pass SHALL need a start while in IDLE.

Reset
REQ-018 rst=1 SHALL force IDLE, counter=0, sample register=0, and in_ready, mem_ren, out_valid, out_last, busy, done all 0 on the next edge.
REQ-019 rst asserted mid-pass SHALL abandon the pass with no done and no out_valid in the cycle after reset.
REQ-020 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-021 numWeight=4, start, in_valid held high with samples 1,2,3,4, memory words 10,20,30,40 -> mem_raddr 0,1,2,3 on consecutive cycles; pairs (1,10),(2,20),(3,30),(4,40) one cycle later; out_last and done only with (4,40); busy=0 next cycle.
REQ-022 numWeight=4, in_valid pattern 1,0,0,1,1,0,1 -> out_valid pattern delayed by exactly one cycle, addresses 0..3 in order, no duplicates.
REQ-023 Second start pulse during RUN at counter=2 -> no counter clear; pass completes normally with one done pulse.
REQ-024 rst asserted at counter=2 in RUN -> all outputs 0 next cycle, no done; a following start and 4 accepts read addresses 0..3 again.
REQ-025 numWeight=1, start then one sample 7 with weight 99 -> pair (7,99) with out_last=1 and done=1; in_ready=0 thereafter.
REQ-026 in_valid high while IDLE (no start) -> in_ready=0, mem_ren=0, out_valid=0 throughout.
